// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: memory-access pipeline stage (between EX and WB).
// Accepts an op from EX. A load waits for a data-SRAM data_ok pulse. If WB
// is stalling when the data arrives, it is held in a one-entry buffer. Load
// data is aligned and sign- or zero-extended. A flush kills the op in MS.
// When the killed op is a load whose response is still outstanding, that
// response is remembered in a counter so that it can be discarded later.
// The stage also drives forwarding and interlock information to ID.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   ws_allowin            WB can accept this cycle
//   ms_allowin            MS can accept from EX
//   es_to_ms_valid/bus    op from EX {pc, dest, gr_we, is_load, load_op, alu_result}
//   ms_to_ws_valid/bus    op to WB   {pc, dest, gr_we, final_result}
//   ms_flush              kill the op in MS
//   data_sram_data_ok     one-cycle read-data-valid pulse (oldest request)
//   data_sram_rdata       read data
//   ms_fwd_we/dest/data   forwarding info for ID
//   ms_fwd_stall          load in MS without data yet; ID must interlock
module mem_stage_lsu #(
  parameter int PC_W         = 32,
  parameter int REG_ADDR_W   = 5,
  parameter int CANCEL_CNT_W = 2,
  parameter int ES_WD        = PC_W + REG_ADDR_W + 37,
  parameter int MS_WD        = PC_W + REG_ADDR_W + 33
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ws_allowin,
  output logic                  ms_allowin,
  input  logic                  es_to_ms_valid,
  input  logic [ES_WD-1:0]      es_to_ms_bus,
  output logic                  ms_to_ws_valid,
  output logic [MS_WD-1:0]      ms_to_ws_bus,
  input  logic                  ms_flush,
  input  logic                  data_sram_data_ok,
  input  logic [31:0]           data_sram_rdata,
  output logic                  ms_fwd_we,
  output logic [REG_ADDR_W-1:0] ms_fwd_dest,
  output logic [31:0]           ms_fwd_data,
  output logic                  ms_fwd_stall
);

  logic                    ms_valid;
  logic [ES_WD-1:0]        ms_bus;
  logic                    buf_valid;
  logic [31:0]             buf_data;
  logic [CANCEL_CNT_W-1:0] cancel_cnt;
  logic [CANCEL_CNT_W-1:0] cancel_next;

  logic [PC_W-1:0]         pc;
  logic [REG_ADDR_W-1:0]   dest;
  logic                    gr_we;
  logic                    is_load;
  logic [2:0]              load_op;
  logic [31:0]             alu_result;

  logic                    cancel_idle;
  logic                    data_live;
  logic                    data_use;
  logic                    ms_ready_go;
  logic                    leave;
  logic                    cancel_inc;
  logic                    cancel_dec;
  logic [31:0]             raw;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [31:0]             aligned;
  logic [31:0]             final_result;

  assign pc         = ms_bus[ES_WD-1 -: PC_W];
  assign dest       = ms_bus[37 +: REG_ADDR_W];
  assign gr_we      = ms_bus[36];
  assign is_load    = ms_bus[35];
  assign load_op    = ms_bus[34:32];
  assign alu_result = ms_bus[31:0];

  // While any cancelled response is still pending, an arriving data_ok
  // belongs to a killed load. It never counts as data for the current op.
  assign cancel_idle = (cancel_cnt == {CANCEL_CNT_W{1'b0}});
  assign data_live   = data_sram_data_ok & cancel_idle;
  assign data_use    = data_live & ms_valid & is_load & ~buf_valid;

  assign ms_ready_go    = ~is_load | buf_valid | data_live;
  assign ms_allowin     = ~ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go & ~ms_flush;
  assign leave          = ms_to_ws_valid & ws_allowin;

  // A flushed load whose response is still owed leaves a response to discard.
  assign cancel_inc = ms_flush & ms_valid & is_load & ~buf_valid & ~data_use;
  assign cancel_dec = data_sram_data_ok & ~cancel_idle;

  // Load data alignment and extension.
  always_comb begin
    raw     = data_sram_data_ok ? data_sram_rdata : buf_data;
    ld_byte = 8'h00;
    ld_half = 16'h0000;
    aligned = raw;
    case (alu_result[1:0])
      2'd0:    ld_byte = raw[7:0];
      2'd1:    ld_byte = raw[15:8];
      2'd2:    ld_byte = raw[23:16];
      2'd3:    ld_byte = raw[31:24];
      default: ld_byte = raw[7:0];
    endcase
    if (alu_result[1]) begin
      ld_half = raw[31:16];
    end else begin
      ld_half = raw[15:0];
    end
    case (load_op)
      3'b000:  aligned = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  aligned = {24'h000000, ld_byte};
      3'b001:  aligned = {{16{ld_half[15]}}, ld_half};
      3'b101:  aligned = {16'h0000, ld_half};
      default: aligned = raw;
    endcase
    if (is_load) begin
      final_result = aligned;
    end else begin
      final_result = alu_result;
    end
  end

  // Next value of the cancelled-response counter. It saturates at its maximum.
  // An increment and a decrement in the same cycle cancel each other out.
  always_comb begin
    cancel_next = cancel_cnt;
    case ({cancel_inc, cancel_dec})
      2'b10: begin
        if (cancel_cnt != {CANCEL_CNT_W{1'b1}}) begin
          cancel_next = cancel_cnt + CANCEL_CNT_W'(1);
        end else begin
          cancel_next = cancel_cnt;
        end
      end
      2'b01:   cancel_next = cancel_cnt - CANCEL_CNT_W'(1);
      default: cancel_next = cancel_cnt;
    endcase
  end

  // Stage valid bit and bus register. On a flush, any op offered by EX is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
      ms_bus   <= {ES_WD{1'b0}};
    end else if (ms_flush) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
      if (es_to_ms_valid) begin
        ms_bus <= es_to_ms_bus;
      end
    end
  end

  // Holds load data that arrived while WB was stalling.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_data  <= 32'h0000_0000;
    end else if (ms_flush || leave) begin
      buf_valid <= 1'b0;
    end else if (data_use && !ws_allowin) begin
      buf_valid <= 1'b1;
      buf_data  <= data_sram_rdata;
    end
  end

  // Cancelled-response counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cancel_cnt <= {CANCEL_CNT_W{1'b0}};
    end else begin
      cancel_cnt <= cancel_next;
    end
  end

  assign ms_to_ws_bus = {pc, dest, gr_we, final_result};
  assign ms_fwd_we    = ms_valid & gr_we;
  assign ms_fwd_dest  = dest;
  assign ms_fwd_data  = final_result;
  assign ms_fwd_stall = ms_valid & is_load & ~ms_ready_go;

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Parametrised memory-access pipeline stage, placed between EX and WB in the mycpu five-stage pipeline. It takes the next place in the design after the bare mem stage. It accepts a load/store/ALU op from EX, waits for a variable-latency data-SRAM response (data_ok), buffers the response if WB stalls, and aligns/extends load data. It also supports pipeline flush with cancellation of in-flight load responses, and drives forwarding/interlock info to ID.

Parameters:
PC_W, 32, PC width carried on the buses
REG_ADDR_W, 5, GPR destination index width
CANCEL_CNT_W, 2, width of the cancelled-response counter (max 2^CANCEL_CNT_W-1 outstanding cancelled loads)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ws_allowin  in  1  WB can accept this cycle
ms_allowin  out  1  MS can accept from EX
es_to_ms_valid  in  1  EX holds valid op ready to go
es_to_ms_bus  in  ES_WD=PC_W+REG_ADDR_W+37  {pc, dest, gr_we, is_load, load_op[2:0], alu_result[31:0]}
ms_to_ws_valid  out  1  MS hands op to WB
ms_to_ws_bus  out  MS_WD=PC_W+REG_ADDR_W+33  {pc, dest, gr_we, final_result[31:0]}
ms_flush  in  1  kill op in MS (exception/redirect)
data_sram_data_ok  in  1  one-cycle pulse: read data valid for oldest outstanding request
data_sram_rdata  in  32  read data, valid with data_ok
ms_fwd_we  out  1  MS holds valid op writing a GPR
ms_fwd_dest  out  REG_ADDR_W  its destination
ms_fwd_data  out  32  its final_result (valid when ms_fwd_stall=0)
ms_fwd_stall  out  1  load in MS without data yet; ID must interlock

Behaviour:
- Reset (sync, highest priority): ms_valid=0, bus register=0, rdata buffer valid=0, cancel_cnt=0. Thus ms_allowin=1, ms_to_ws_valid=0, ms_to_ws_bus=0, all ms_fwd_* =0.
- Accept: on es_to_ms_valid && ms_allowin && !ms_flush, latch the bus and set ms_valid=1. Else if ms_allowin, ms_valid<=0.
- ms_ready_go = !is_load | buf_valid | (data_ok && cancel_cnt==0).
- ms_allowin = !ms_valid | (ms_ready_go & ws_allowin). ms_to_ws_valid = ms_valid & ms_ready_go & !ms_flush.
- data_ok consumption priority: if cancel_cnt!=0 the pulse is discarded and cancel_cnt decrements. Else if ms_valid & is_load & !buf_valid, the data is used. It goes straight through if ws_allowin, and is latched into buf (buf_valid=1) if WB stalls. Else the pulse is ignored (no request outstanding).
- buf_valid clears when the op leaves MS (ms_to_ws_valid & ws_allowin) or on flush.
- Flush: ms_valid<=0 and buf_valid<=0. If MS held a load with no data yet (!buf_valid and no usable data_ok this cycle), cancel_cnt increments. A flush in the same cycle as usable data_ok does not increment. The counter saturates at max; overflow is a protocol violation.
- Simultaneous flush and EX handoff: flush wins and the incoming op is dropped.
- Load alignment uses a=alu_result[1:0] and raw = data_ok ? rdata : buf:
  - 000 ld.b: sext byte raw[8a+7:8a]
  - 100 ld.bu: zext of the same byte
  - 001 ld.h: sext half raw[16a[1]+15:16a[1]]
  - 101 ld.hu: zext of the same half
  - 010 and all other codes: ld.w, raw unchanged
  - a[0] for halves is ignored (alignment fault handled in EX).
- final_result = is_load ? aligned : alu_result. Stores travel with is_load=0 and need no data_ok.
- Forwarding: ms_fwd_we=ms_valid&gr_we; ms_fwd_dest=dest; ms_fwd_data=final_result; ms_fwd_stall=ms_valid&is_load&!ms_ready_go.
- Latency: a non-load op presents to WB the cycle after acceptance. A load presents in the cycle of its data_ok at the earliest.

Test Plan:
- ALU op, alu_result=0x1234_5678, gr_we=1, ws_allowin=1 -> next cycle ms_to_ws_valid=1, final_result=0x12345678, ms_allowin stays 1.
- ld.b, addr[1:0]=3, data_ok 2 cycles later with rdata=0x80FF_0000 -> ms_fwd_stall=1 for 2 cycles, then final_result=0xFFFF_FF80. ld.bu on the same data -> 0x0000_0080. ld.hu with a=2 -> 0x0000_80FF.
- ld.w, data_ok=1 with rdata=0xDEAD_BEEF while ws_allowin=0 for 3 cycles -> buf holds the data, ms_to_ws_valid=1 throughout, ms_allowin=0. Handoff occurs on the cycle ws_allowin=1 with result 0xDEADBEEF.
- ld.w waiting, ms_flush=1 -> ms_valid=0, cancel_cnt=1. The next load is accepted, and the first data_ok (0x1111_1111) is discarded. The second data_ok (0x2222_2222) completes the new load.
- Flush in the same cycle as usable data_ok -> cancel_cnt stays 0. The EX op offered the same cycle is dropped (ms_valid=0 next cycle).
- Reset asserted mid-wait with buf_valid=1 and cancel_cnt=1 -> next cycle all state is 0, ms_allowin=1, ms_to_ws_valid=0.
